// File: rtl/mmio_stream_port.sv
// Memory-mapped bridge between the core data bus and two 32-bit streams.
// TX FIFO is filled by stores and drained by a sink; RX FIFO the reverse.
module mmio_stream_port #(
    parameter logic [31:0] BASE_ADDR = 32'hFF20_0100,
    parameter int          DEPTH     = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        DwReadEnable,
    input  logic        DwWriteEnable,
    input  logic [3:0]  DwByteEnable,
    input  logic [31:0] DwAddress,
    input  logic [31:0] DwWriteData,
    output logic [31:0] DwReadData,
    output logic [31:0] oTxData,
    output logic        oTxValid,
    input  logic        iTxReady,
    input  logic [31:0] iRxData,
    input  logic        iRxValid,
    output logic        oRxReady,
    output logic        oIrq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   tx_mem_q [DEPTH];
    logic [31:0]   rx_mem_q [DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_drop_q, tx_drop_d, be_err_q, be_err_d;

    logic        hit, rd_hit, wr_hit;
    logic [1:0]  off;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        data_wr, be_ok, tx_req, tx_push, tx_pop;
    logic        rx_push, rx_pop;
    logic        ctrl_wr, clr, tx_flush, rx_flush;
    logic [31:0] status, rdata;
    logic        unused;

    assign unused = &{1'b0, DwAddress[1:0]};

    assign hit    = DwAddress[31:4] == BASE_ADDR[31:4];
    assign off    = DwAddress[3:2];
    assign rd_hit = DwReadEnable & hit;
    assign wr_hit = DwWriteEnable & hit;

    assign tx_full  = tx_cnt_q == FULL;
    assign tx_empty = tx_cnt_q == '0;
    assign rx_full  = rx_cnt_q == FULL;
    assign rx_empty = rx_cnt_q == '0;

    assign data_wr = wr_hit & (off == 2'd0);
    assign be_ok   = DwByteEnable == 4'b1111;
    assign tx_req  = data_wr & be_ok;
    assign tx_pop  = !tx_empty & iTxReady;
    // A full FIFO still takes the store when the sink frees a slot this edge.
    assign tx_push = tx_req & (!tx_full | tx_pop);

    assign ctrl_wr  = wr_hit & (off == 2'd2);
    assign clr      = ctrl_wr & DwWriteData[0];
    assign tx_flush = ctrl_wr & DwWriteData[1];
    assign rx_flush = ctrl_wr & DwWriteData[2];

    assign oRxReady = !rx_full & !iRST;
    assign rx_push  = iRxValid & oRxReady;
    assign rx_pop   = rd_hit & (off == 2'd0) & !rx_empty;

    assign oTxData  = tx_mem_q[tx_rptr_q];
    assign oTxValid = !tx_empty;
    assign oIrq     = !rx_empty;

    assign status = {8'h00, 8'(rx_cnt_q), 8'(tx_cnt_q), 2'b00,
                     be_err_q, tx_drop_q,
                     rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        rdata = 32'h0;
        case (off)
            2'd0:    rdata = rx_empty ? 32'h0 : rx_mem_q[rx_rptr_q];
            2'd1:    rdata = status;
            default: rdata = 32'h0;
        endcase
    end

    assign DwReadData = rd_hit ? rdata : 32'h0;

    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_flush) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            tx_cnt_d  = '0;
        end else begin
            if (tx_push) tx_wptr_d = tx_wptr_q + AW'(1);
            if (tx_pop)  tx_rptr_d = tx_rptr_q + AW'(1);
            if (tx_push & !tx_pop)      tx_cnt_d = tx_cnt_q + CW'(1);
            else if (!tx_push & tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
        end
    end

    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_flush) begin
            rx_wptr_d = '0;
            rx_rptr_d = '0;
            rx_cnt_d  = '0;
        end else begin
            if (rx_push) rx_wptr_d = rx_wptr_q + AW'(1);
            if (rx_pop)  rx_rptr_d = rx_rptr_q + AW'(1);
            if (rx_push & !rx_pop)      rx_cnt_d = rx_cnt_q + CW'(1);
            else if (!rx_push & rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
        end
    end

    // Set wins over a same-cycle clear.
    assign tx_drop_d = (tx_req & !tx_push) | (tx_drop_q & !clr);
    assign be_err_d  = (data_wr & !be_ok) | (be_err_q & !clr);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            tx_drop_q <= 1'b0;
            be_err_q  <= 1'b0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_drop_q <= tx_drop_d;
            be_err_q  <= be_err_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (tx_push & !tx_flush) tx_mem_q[tx_wptr_q] <= DwWriteData;
        if (rx_push & !rx_flush) rx_mem_q[rx_wptr_q] <= iRxData;
    end

endmodule

// File: tb/tb_mmio_stream_port.sv
// Directed bench for mmio_stream_port: vector table plus
// hand-written sequences for full/drop, flush and reset.
module tb_mmio_stream_port;

    localparam logic [31:0] BASE = 32'hFF20_0100;
    localparam logic [31:0] DATA = BASE;
    localparam logic [31:0] STAT = BASE + 32'h4;
    localparam logic [31:0] CTRL = BASE + 32'h8;
    localparam logic [31:0] REG3 = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr;
    logic [3:0]  be;
    logic [31:0] addr, wd, rdata;
    logic [31:0] txd;
    logic        txv, txr;
    logic [31:0] rxd;
    logic        rxv, rxr, irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_stream_port #(.BASE_ADDR(BASE), .DEPTH(16)) dut (
        .iCLK(clk),
        .iRST(rst),
        .DwReadEnable(rd),
        .DwWriteEnable(wr),
        .DwByteEnable(be),
        .DwAddress(addr),
        .DwWriteData(wd),
        .DwReadData(rdata),
        .oTxData(txd),
        .oTxValid(txv),
        .iTxReady(txr),
        .iRxData(rxd),
        .iRxValid(rxv),
        .oRxReady(rxr),
        .oIrq(irq)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        txr;
        logic        rxv;
        logic [31:0] rxd;
        logic [31:0] e_rd;
        logic        e_txv;
        logic        chk_txd;
        logic [31:0] e_txd;
        logic        e_irq;
        logic        e_rxr;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic tr, input logic rv,
                         input logic [31:0] rd_data);
        rd   = r;
        wr   = w;
        be   = b;
        addr = a;
        wd   = d;
        txr  = tr;
        rxv  = rv;
        rxd  = rd_data;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        drive(0, 1, 4'hF, a, d, 0, 0, 32'h0);
        tick();
        idle();
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a,
                          input logic [31:0] exp);
        drive(1, 0, 4'hF, a, 32'h0, 0, 0, 32'h0);
        #2;
        chk(nm, rdata, exp);
        tick();
        idle();
    endtask

    initial begin
        vecs[0]  = '{1, 0, STAT, 0, 0, 0, 0, 32'h0000_000A, 0, 0, 0, 0, 1};
        vecs[1]  = '{0, 1, DATA, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[2]  = '{0, 1, DATA, 32'h22, 0, 0, 0, 0, 1, 1, 32'h11, 0, 1};
        vecs[3]  = '{0, 1, DATA, 32'h33, 0, 0, 0, 0, 1, 1, 32'h11, 0, 1};
        vecs[4]  = '{1, 0, STAT, 0, 0, 0, 0, 32'h0000_0308, 1, 1, 32'h11, 0, 1};
        vecs[5]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h11, 0, 1};
        vecs[6]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h22, 0, 1};
        vecs[7]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h33, 0, 1};
        vecs[8]  = '{1, 0, STAT, 0, 0, 0, 0, 32'h0000_000A, 0, 0, 0, 0, 1};
        vecs[9]  = '{0, 0, 0, 0, 0, 1, 32'hA5A5_0001, 0, 0, 0, 0, 0, 1};
        vecs[10] = '{1, 0, STAT, 0, 0, 1, 32'hA5A5_0002, 32'h0001_0002, 0, 0, 0, 1, 1};
        vecs[11] = '{1, 0, DATA, 0, 0, 0, 0, 32'hA5A5_0001, 0, 0, 0, 1, 1};
        vecs[12] = '{1, 0, DATA, 0, 0, 0, 0, 32'hA5A5_0002, 0, 0, 0, 1, 1};
        vecs[13] = '{1, 0, DATA, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1};
        vecs[14] = '{1, 0, STAT, 0, 0, 0, 0, 32'h0000_000A, 0, 0, 0, 0, 1};
        vecs[15] = '{1, 0, BASE + 32'h10, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1};
        vecs[16] = '{1, 0, REG3, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1};
        vecs[17] = '{1, 0, CTRL, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1};

        rst = 1'b1;
        idle();
        tick();
        tick();
        chk("rxready in reset", {31'h0, rxr}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rd, vecs[i].wr, 4'hF, vecs[i].addr, vecs[i].wd,
                  vecs[i].txr, vecs[i].rxv, vecs[i].rxd);
            #2;
            chk($sformatf("vec%0d rdata", i), rdata, vecs[i].e_rd);
            chk($sformatf("vec%0d txvalid", i), {31'h0, txv},
                {31'h0, vecs[i].e_txv});
            if (vecs[i].chk_txd)
                chk($sformatf("vec%0d txdata", i), txd, vecs[i].e_txd);
            chk($sformatf("vec%0d irq", i), {31'h0, irq},
                {31'h0, vecs[i].e_irq});
            chk($sformatf("vec%0d rxready", i), {31'h0, rxr},
                {31'h0, vecs[i].e_rxr});
            tick();
        end
        idle();

        for (int i = 0; i < 16; i++) wr_reg(DATA, 32'h100 + i);
        rd_chk("tx full status", STAT, 32'h0000_1009);
        wr_reg(DATA, 32'hDEAD);
        rd_chk("tx drop status", STAT, 32'h0000_1019);
        drive(0, 1, 4'hF, DATA, 32'hDEAD, 1, 0, 32'h0);
        #2;
        chk("full push head", txd, 32'h100);
        tick();
        idle();
        rd_chk("full push+pop status", STAT, 32'h0000_1019);
        for (int i = 1; i < 16; i++) begin
            drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
            #2;
            chk($sformatf("drain %0d", i), txd, 32'h100 + i);
            tick();
        end
        drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
        #2;
        chk("drain last", txd, 32'hDEAD);
        tick();
        idle();
        #2;
        chk("drained txvalid", {31'h0, txv}, 32'h0);
        rd_chk("drop kept", STAT, 32'h0000_001A);
        wr_reg(CTRL, 32'h1);
        rd_chk("drop cleared", STAT, 32'h0000_000A);

        drive(0, 1, 4'b0011, DATA, 32'h77, 0, 0, 32'h0);
        tick();
        idle();
        rd_chk("be_err status", STAT, 32'h0000_002A);
        chk("be_err no push", {31'h0, txv}, 32'h0);
        wr_reg(CTRL, 32'h1);
        rd_chk("be_err cleared", STAT, 32'h0000_000A);

        drive(0, 1, 4'hF, DATA, 32'h55, 0, 1, 32'h99);
        tick();
        rd_chk("pre-flush status", STAT, 32'h0001_0100);
        drive(0, 1, 4'hF, CTRL, 32'h6, 0, 1, 32'h77);
        tick();
        idle();
        #2;
        chk("flush txvalid", {31'h0, txv}, 32'h0);
        chk("flush irq", {31'h0, irq}, 32'h0);
        rd_chk("flush status", STAT, 32'h0000_000A);

        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h200 + i);
            #2;
            if (i == 15) chk("rxready before full", {31'h0, rxr}, 32'h1);
            tick();
        end
        idle();
        #2;
        chk("rx full rxready", {31'h0, rxr}, 32'h0);
        rd_chk("rx full status", STAT, 32'h0010_0006);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hBAD);
        tick();
        rd_chk("rx full head", DATA, 32'h200);
        rd_chk("rx after pop", STAT, 32'h000F_0002);
        chk("rxready after pop", {31'h0, rxr}, 32'h1);
        rd_chk("rx next head", DATA, 32'h201);
        wr_reg(CTRL, 32'h4);
        rd_chk("rx flushed", STAT, 32'h0000_000A);

        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 4'hF, DATA, 32'h300 + i, 0, i < 3, 32'h400 + i);
            tick();
        end
        idle();
        rd_chk("pre-reset status", STAT, 32'h0003_0500);
        rst = 1'b1;
        #2;
        chk("reset rxready", {31'h0, rxr}, 32'h0);
        tick();
        rst = 1'b0;
        #2;
        chk("post-reset txvalid", {31'h0, txv}, 32'h0);
        chk("post-reset irq", {31'h0, irq}, 32'h0);
        chk("post-reset rxready", {31'h0, rxr}, 32'h1);
        rd_chk("post-reset status", STAT, 32'h0000_000A);
        wr_reg(DATA, 32'hAB);
        #2;
        chk("post-reset push valid", {31'h0, txv}, 32'h1);
        chk("post-reset push data", txd, 32'hAB);

        rd_chk("miss above", BASE + 32'h10, 32'h0);
        rd_chk("miss below", BASE - 32'h4, 32'h0);
        rd_chk("miss low", 32'h0000_0100, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_stream_port.md
# mmio_stream_port

Memory-mapped responder on the processor data bus (Dw* signals). It bridges the core to two byte-free 32-bit streams: a TX FIFO, which core stores fill and an external sink drains, and an RX FIFO, which an external source fills and core loads drain. Reads return data combinationally in the same cycle, so the single-cycle datapath can consume it. All state changes occur on the clock edge.

## Interface
- BASE_ADDR, 32'hFF20_0100: 16-byte-aligned base of the register window.
- DEPTH, 16: entries per FIFO. Must be a power of two, 2..128.
- iCLK in 1: clock.
- iRST in 1: synchronous, active-high reset.
- DwReadEnable in 1: bus read strobe.
- DwWriteEnable in 1: bus write strobe.
- DwByteEnable in 4: lane enables.
- DwAddress in 32: byte address.
- DwWriteData in 32: store data.
- DwReadData out 32: load data. Forced to 0 when the access is not a read hit, so the bus can OR-combine responders.
- oTxData out 32: head of the TX FIFO.
- oTxValid out 1: TX FIFO is not empty.
- iTxReady in 1: sink accepts oTxData at this edge.
- iRxData in 32: source data.
- iRxValid in 1: source has data.
- oRxReady out 1: the RX FIFO can accept data.
- oIrq out 1: RX FIFO is not empty.

## Operation
- Hit: DwAddress[31:4] == BASE_ADDR[31:4].
- Register selection uses offset = DwAddress[3:2].
- Offset 0, DATA:
  - Write: pushes DwWriteData to TX. Accepted only if DwByteEnable == 4'b1111, else ignored and be_err is set.
  - Read: returns the RX head. It pops at the edge if RX is not empty. A read of an empty RX returns 0 and does not pop.
- Offset 1, STATUS (read-only; writes ignored):
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
  - [4] tx_drop (sticky), [5] be_err (sticky).
  - [15:8] tx_count, [23:16] rx_count. All other bits 0.
- Offset 2, CONTROL (write-only; reads 0; written bits are one-shot):
  - Bit 0 clears tx_drop and be_err.
  - Bit 1 flushes TX.
  - Bit 2 flushes RX.
- Offset 3 reads 0; writes to it are ignored.
- TX push is accepted when the write is not full, or when a TX pop happens in the same cycle (oTxValid & iTxReady).
  - Otherwise the write is dropped and tx_drop is set.
- TX pop: oTxValid & iTxReady at the edge.
- RX push: iRxValid & oRxReady at the edge. oRxReady = !rx_full & !iRST, so there is no combinational path from the CPU pop.
- Counts:
  - Width is log2(DEPTH)+1, zero-extended into STATUS.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Flush has priority over a same-cycle push or pop: the FIFO is empty after the edge and the pushed word is discarded.
- Sticky set and clear in the same cycle: set wins.
- DwReadEnable and DwWriteEnable both high at a hit: both actions are performed.

## Timing
- Reset is synchronous. At any edge with iRST=1:
  - Pointers, counts, tx_drop and be_err are cleared.
  - oTxValid=0, oIrq=0, oRxReady=0.
  - DwReadData follows the reset state (STATUS reads 32'h0000_000A).
- Reset mid-transfer discards all FIFO contents. The first edge after iRST falls accepts traffic normally.
- Store at edge k: oTxValid=1 and oTxData valid from cycle k+1.
- RX accepted at edge k: oIrq=1 and DwReadData(DATA) shows the word in cycle k+1.
- Load is zero-wait: DwReadData is combinational from the address and the current state. The pop takes effect at the end of the same cycle.
- Read-after-pop: STATUS counts reflect the state at the start of the cycle.
- Full/empty flags derive only from registered state.

## Test plan
- Reset, then read STATUS: DwReadData = 32'h0000_000A; oTxValid=0, oIrq=0, oRxReady=1 after iRST falls.
- TX ordering and backpressure:
  - Stimulus: store 0x11,0x22,0x33 to DATA with iTxReady=0.
  - Check STATUS tx_count=3.
  - Then raise iTxReady: oTxData sequence 0x11,0x22,0x33 on three consecutive edges, then oTxValid=0.
- TX full and drop:
  - Stimulus: fill with 16 words, iTxReady=0, then store 0xDEAD.
  - Check: tx_full=1, tx_drop=1, count stays 16.
  - Repeat the store with iTxReady=1 in the same cycle: accepted, count stays 16, tx_drop unchanged.
- RX path:
  - Stimulus: push 0xA5A5_0001 and 0xA5A5_0002 via iRxValid.
  - Check: oIrq=1.
  - Two loads from DATA return them in order; a third load returns 0 with rx_count=0.
  - Fill RX to 16 and check oRxReady=0.
- Byte-enable error and clear:
  - Stimulus: store to DATA with DwByteEnable=4'b0011.
  - Check: TX unchanged, be_err=1.
  - Write CONTROL=1: STATUS[5:4]=0.
  - Write CONTROL=6 with both FIFOs non-empty: tx_empty=1, rx_empty=1 next cycle.
- Reset mid-operation: assert iRST for one cycle with TX=5 and RX=3 entries → all counts 0, oTxValid=0, oIrq=0; non-hit addresses always read 0.
